// File: rtl/midi_voice_alloc.sv
// -----------------------------------------------------------------------------
// midi_voice_alloc
//
// Polyphonic voice allocator. Each completed 3-byte MIDI message is decoded and
// turned into a load strobe (Note On), a single clear strobe (Note Off) or a
// broadcast clear (All Notes Off) towards the per-voice data registers. Any
// accepted MIDI channel may play any voice.
//
// Ports:
//   Clk        system clock
//   Rst_p      synchronous active-high reset
//   MIDI_data  {status, data1, data2}, valid while RxDne = 1
//   RxDne      one-cycle strobe announcing a new message
//   RegData    {1'b0, note, 1'b0, vel} for the register being loaded
//   RegEn      one-hot load strobe (one cycle)
//   RegClr     clear strobe (one cycle), one-hot or all ones
//   Active     voice occupancy, bit v = voice v holds a note
//   Overrun    one-cycle pulse when a message arrives while busy
// -----------------------------------------------------------------------------
module midi_voice_alloc #(
    parameter int          VOICES    = 8,
    parameter logic [15:0] CHAN_MASK = 16'hFFFF
) (
    input  logic              Clk,
    input  logic              Rst_p,
    input  logic [23:0]       MIDI_data,
    input  logic              RxDne,
    output logic [15:0]       RegData,
    output logic [VOICES-1:0] RegEn,
    output logic [VOICES-1:0] RegClr,
    output logic [VOICES-1:0] Active,
    output logic              Overrun
);

    localparam int PW = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_SEARCH = 2'd2,
        ST_ISSUE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CL_IGNORE  = 2'd0,
        CL_NOTEON  = 2'd1,
        CL_NOTEOFF = 2'd2,
        CL_ALLOFF  = 2'd3
    } class_t;

    state_t            state_q, state_d;
    class_t            cls_q, cls_d;
    logic [23:0]       msg_q, msg_d;
    logic [VOICES-1:0] valid_q, valid_d;
    logic [6:0]        note_q [VOICES];
    logic [6:0]        note_d [VOICES];
    logic [PW-1:0]     steal_q, steal_d;
    logic [15:0]       regdata_q, regdata_d;
    logic [VOICES-1:0] regen_q, regen_d;
    logic [VOICES-1:0] regclr_q, regclr_d;
    logic              overrun_q, overrun_d;

    logic [VOICES-1:0] hit_s;
    logic [VOICES-1:0] free_s;
    logic [PW-1:0]     match_idx_s;
    logic [PW-1:0]     free_idx_s;
    logic [6:0]        note_s;
    logic [6:0]        vel_s;

    // Message classification; channel is only used for the accept mask.
    function automatic class_t classify(input logic [23:0] msg);
        logic [3:0] cmd;
        logic [3:0] chan;
        class_t     res;
        cmd  = msg[23:20];
        chan = msg[19:16];
        if ((CHAN_MASK[chan] == 1'b0) || msg[15] || msg[7]) begin
            res = CL_IGNORE;
        end else if ((cmd == 4'h9) && (msg[6:0] != 7'd0)) begin
            res = CL_NOTEON;
        end else if ((cmd == 4'h8) || (cmd == 4'h9)) begin
            res = CL_NOTEOFF;
        end else if ((cmd == 4'hB) && ((msg[15:8] == 8'd120) || (msg[15:8] == 8'd123))) begin
            res = CL_ALLOFF;
        end else begin
            res = CL_IGNORE;
        end
        return res;
    endfunction

    // Index of the lowest set bit; scanning downwards lets lower indices win.
    function automatic logic [PW-1:0] lowest_idx(input logic [VOICES-1:0] vec);
        logic [PW-1:0] idx;
        idx = {PW{1'b0}};
        for (int i = VOICES - 1; i >= 0; i--) begin
            idx = vec[i] ? PW'(i) : idx;
        end
        return idx;
    endfunction

    assign note_s = msg_q[14:8];
    assign vel_s  = msg_q[6:0];

    // Note-table lookup: matching valid voices and empty voices.
    always_comb begin
        hit_s  = '0;
        free_s = ~valid_q;
        for (int v = 0; v < VOICES; v++) begin
            hit_s[v] = valid_q[v] && (note_q[v] == note_s);
        end
        match_idx_s = lowest_idx(hit_s);
        free_idx_s  = lowest_idx(free_s);
    end

    // Next-state logic; strobes are computed in SEARCH so they are visible
    // during the ISSUE cycle, together with the updated table.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        msg_d     = msg_q;
        valid_d   = valid_q;
        note_d    = note_q;
        steal_d   = steal_q;
        regdata_d = regdata_q;
        regen_d   = '0;
        regclr_d  = '0;
        overrun_d = RxDne && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (RxDne) begin
                    msg_d   = MIDI_data;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                cls_d   = classify(msg_q);
                state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                state_d = ST_ISSUE;
                case (cls_q)
                    CL_NOTEON: begin
                        regdata_d = {1'b0, note_s, 1'b0, vel_s};
                        if (hit_s != '0) begin
                            // Same pitch already sounding: retrigger in place.
                            regen_d[match_idx_s] = 1'b1;
                        end else if (free_s != '0) begin
                            regen_d[free_idx_s] = 1'b1;
                            valid_d[free_idx_s] = 1'b1;
                            note_d[free_idx_s]  = note_s;
                        end else begin
                            // All voices busy: round-robin steal.
                            regen_d[steal_q] = 1'b1;
                            note_d[steal_q]  = note_s;
                            steal_d = (steal_q == PW'(VOICES - 1)) ? {PW{1'b0}}
                                                                   : steal_q + {{(PW-1){1'b0}}, 1'b1};
                        end
                    end
                    CL_NOTEOFF: begin
                        if (hit_s != '0) begin
                            regclr_d[match_idx_s] = 1'b1;
                            valid_d[match_idx_s]  = 1'b0;
                            regdata_d             = 16'h0000;
                        end else begin
                            regdata_d = regdata_q;
                        end
                    end
                    CL_ALLOFF: begin
                        regclr_d  = '1;
                        valid_d   = '0;
                        steal_d   = {PW{1'b0}};
                        regdata_d = 16'h0000;
                    end
                    default: begin
                        regdata_d = regdata_q;
                    end
                endcase
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst_p) begin
            state_q   <= ST_IDLE;
            cls_q     <= CL_IGNORE;
            msg_q     <= 24'h000000;
            valid_q   <= '0;
            steal_q   <= {PW{1'b0}};
            regdata_q <= 16'h0000;
            regen_q   <= '0;
            regclr_q  <= '0;
            overrun_q <= 1'b0;
            for (int v = 0; v < VOICES; v++) begin
                note_q[v] <= 7'd0;
            end
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            msg_q     <= msg_d;
            valid_q   <= valid_d;
            steal_q   <= steal_d;
            regdata_q <= regdata_d;
            regen_q   <= regen_d;
            regclr_q  <= regclr_d;
            overrun_q <= overrun_d;
            for (int v = 0; v < VOICES; v++) begin
                note_q[v] <= note_d[v];
            end
        end
    end

    assign RegData = regdata_q;
    assign RegEn   = regen_q;
    assign RegClr  = regclr_q;
    assign Active  = valid_q;
    assign Overrun = overrun_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for midi_voice_alloc. Stimulus pushes the expected strobe
// (cycle, RegEn, RegClr, RegData, Active) into a queue; monitors pop and
// compare whenever a DUT issues a strobe or an Overrun pulse. A second
// instance with CHAN_MASK = 16'h0001 covers channel filtering.
// -----------------------------------------------------------------------------
module tb_midi_voice_alloc;

    typedef struct {
        int          cyc;
        logic [7:0]  en;
        logic [7:0]  clr;
        logic [15:0] data;
        logic [7:0]  act;
    } exp_t;

    logic        Clk;
    logic        Rst_p;
    logic [23:0] MIDI_data;
    logic        rx;
    logic        rx_m;

    logic [15:0] reg_data;
    logic [7:0]  reg_en;
    logic [7:0]  reg_clr;
    logic [7:0]  active;
    logic        overrun;

    logic [15:0] reg_data_m;
    logic [7:0]  reg_en_m;
    logic [7:0]  reg_clr_m;
    logic [7:0]  active_m;
    logic        overrun_m;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    exp_t exp_m_q[$];
    int   ovr_q[$];

    midi_voice_alloc #(.VOICES(8), .CHAN_MASK(16'hFFFF)) u_dut (
        .Clk(Clk), .Rst_p(Rst_p), .MIDI_data(MIDI_data), .RxDne(rx),
        .RegData(reg_data), .RegEn(reg_en), .RegClr(reg_clr),
        .Active(active), .Overrun(overrun)
    );

    midi_voice_alloc #(.VOICES(8), .CHAN_MASK(16'h0001)) u_dut_m (
        .Clk(Clk), .Rst_p(Rst_p), .MIDI_data(MIDI_data), .RxDne(rx_m),
        .RegData(reg_data_m), .RegEn(reg_en_m), .RegClr(reg_clr_m),
        .Active(active_m), .Overrun(overrun_m)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Issue one message; optionally queue the strobe expected 3 cycles later.
    task automatic send(input bit to_m, input logic [23:0] msg, input bit has_exp,
                        input logic [7:0] en, input logic [7:0] clr,
                        input logic [15:0] data, input logic [7:0] act);
        exp_t e;
        @(posedge Clk); #1;
        MIDI_data = msg;
        if (to_m) rx_m = 1'b1;
        else      rx   = 1'b1;
        e.cyc = cyc + 3; e.en = en; e.clr = clr; e.data = data; e.act = act;
        if (has_exp && to_m)  exp_m_q.push_back(e);
        if (has_exp && !to_m) exp_q.push_back(e);
        @(posedge Clk); #1;
        rx   = 1'b0;
        rx_m = 1'b0;
        repeat (4) @(posedge Clk);
    endtask

    // Main-instance monitor.
    always @(negedge Clk) begin
        exp_t e;
        if ((reg_en != 8'h00) || (reg_clr != 8'h00)) begin
            if (exp_q.size() == 0) begin
                chk("main_unexpected_strobe", {16'h0000, reg_en, reg_clr}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("main_latency", cyc, e.cyc);
                chk("main_RegEn", {24'h0, reg_en}, {24'h0, e.en});
                chk("main_RegClr", {24'h0, reg_clr}, {24'h0, e.clr});
                chk("main_RegData", {16'h0, reg_data}, {16'h0, e.data});
                chk("main_Active", {24'h0, active}, {24'h0, e.act});
            end
        end
        if (overrun) begin
            if (ovr_q.size() == 0) chk("main_unexpected_overrun", 32'h1, 32'h0);
            else chk("main_overrun_cycle", cyc, ovr_q.pop_front());
        end
    end

    // Masked-instance monitor.
    always @(negedge Clk) begin
        exp_t e;
        if ((reg_en_m != 8'h00) || (reg_clr_m != 8'h00)) begin
            if (exp_m_q.size() == 0) begin
                chk("mask_unexpected_strobe", {16'h0000, reg_en_m, reg_clr_m}, 32'h0);
            end else begin
                e = exp_m_q.pop_front();
                chk("mask_latency", cyc, e.cyc);
                chk("mask_RegEn", {24'h0, reg_en_m}, {24'h0, e.en});
                chk("mask_RegClr", {24'h0, reg_clr_m}, {24'h0, e.clr});
                chk("mask_RegData", {16'h0, reg_data_m}, {16'h0, e.data});
                chk("mask_Active", {24'h0, active_m}, {24'h0, e.act});
            end
        end
        if (overrun_m) chk("mask_unexpected_overrun", 32'h1, 32'h0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        Rst_p     = 1'b1;
        rx        = 1'b0;
        rx_m      = 1'b0;
        MIDI_data = 24'h000000;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_RegData", {16'h0, reg_data}, 32'h0);
        chk("reset_RegEn", {24'h0, reg_en}, 32'h0);
        chk("reset_RegClr", {24'h0, reg_clr}, 32'h0);
        chk("reset_Active", {24'h0, active}, 32'h0);
        chk("reset_Overrun", {31'h0, overrun}, 32'h0);
        Rst_p = 1'b0;
        repeat (2) @(posedge Clk);

        // First note, then retrigger of the same pitch with a new velocity.
        send(1'b0, 24'h903C64, 1'b1, 8'h01, 8'h00, 16'h3C64, 8'h01);
        send(1'b0, 24'h903C40, 1'b1, 8'h01, 8'h00, 16'h3C40, 8'h01);
        // All Notes Off via controller 123.
        send(1'b0, 24'hB07B00, 1'b1, 8'h00, 8'hFF, 16'h0000, 8'h00);
        // Fill all voices with 0x30..0x37.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] nt;
            logic [7:0] en;
            logic [7:0] act;
            nt  = 8'h30 + 8'(i);
            en  = 8'h01 << i;
            act = (8'h02 << i) - 8'h01;
            send(1'b0, {8'h90, nt, 8'h64}, 1'b1, en, 8'h00, {nt, 8'h64}, act);
        end
        // Steals go round-robin from voice 0.
        send(1'b0, 24'h923864, 1'b1, 8'h01, 8'h00, 16'h3864, 8'hFF);
        send(1'b0, 24'h903964, 1'b1, 8'h02, 8'h00, 16'h3964, 8'hFF);
        // Note Off of voice 3, then a vel-0 Note Off with no match.
        send(1'b0, 24'h803300, 1'b1, 8'h00, 8'h08, 16'h0000, 8'hF7);
        send(1'b0, 24'h903300, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00);
        // Freed voice 3 is the lowest free slot.
        send(1'b0, 24'h904A10, 1'b1, 8'h08, 8'h00, 16'h4A10, 8'hFF);
        // data1 with bit 7 set is ignored.
        send(1'b0, 24'h90BC64, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00);
        // Controller 120 also clears everything.
        send(1'b0, 24'hB07800, 1'b1, 8'h00, 8'hFF, 16'h0000, 8'h00);

        // Channel mask instance: channel 1 ignored, channel 0 accepted.
        send(1'b1, 24'h913C64, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00);
        send(1'b1, 24'h903C64, 1'b1, 8'h01, 8'h00, 16'h3C64, 8'h01);
        send(1'b1, 24'hB07B00, 1'b1, 8'h00, 8'hFF, 16'h0000, 8'h00);

        // Overrun: second message two cycles after the first is dropped.
        @(posedge Clk); #1;
        MIDI_data = 24'h905010;
        rx = 1'b1;
        t = cyc;
        begin
            exp_t e;
            e.cyc = t + 3; e.en = 8'h01; e.clr = 8'h00; e.data = 16'h5010; e.act = 8'h01;
            exp_q.push_back(e);
        end
        ovr_q.push_back(t + 3);
        @(posedge Clk); #1;
        rx = 1'b0;
        @(posedge Clk); #1;
        MIDI_data = 24'h906020;
        rx = 1'b1;
        @(posedge Clk); #1;
        rx = 1'b0;
        repeat (5) @(posedge Clk);

        // Reset two cycles into a message aborts it.
        @(posedge Clk); #1;
        MIDI_data = 24'h907070;
        rx = 1'b1;
        @(posedge Clk); #1;
        rx = 1'b0;
        @(posedge Clk); #1;
        Rst_p = 1'b1;
        @(posedge Clk); #1;
        Rst_p = 1'b0;
        chk("midreset_RegEn", {24'h0, reg_en}, 32'h0);
        chk("midreset_RegClr", {24'h0, reg_clr}, 32'h0);
        chk("midreset_RegData", {16'h0, reg_data}, 32'h0);
        chk("midreset_Active", {24'h0, active}, 32'h0);
        repeat (5) @(posedge Clk);
        // Table was cleared, so a new note lands in voice 0.
        send(1'b0, 24'h901111, 1'b1, 8'h01, 8'h00, 16'h1111, 8'h01);

        repeat (5) @(posedge Clk);
        chk("main_expected_left", exp_q.size(), 32'h0);
        chk("mask_expected_left", exp_m_q.size(), 32'h0);
        chk("overrun_expected_left", ovr_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/midi_voice_alloc.md
Name: midi_voice_alloc

Overview:
Polyphonic voice allocator between the MIDI shift register and the eight per-voice data registers. It decodes each completed 3-byte MIDI message and then does one of three things: assigns a Note On to a free or stolen voice, releases the voice holding a Note Off's pitch, or clears all voices on an All-Notes-Off controller. Its outputs (RegData, RegEn, RegClr) drive the MIDI_dataReg instances directly. It replaces fixed channel-to-voice routing so any MIDI channel can play any stepper.

Parameters:
VOICES, 8, number of voice slots; width of RegEn/RegClr/Active.
CHAN_MASK, 16'hFFFF, bit n = 1 means MIDI channel n (0-15) is accepted; other channels are ignored.

Ports:
Clk  input  1  system clock (50 MHz)
Rst_p  input  1  synchronous active-high reset
MIDI_data  input  24  {status, data1, data2}, valid when RxDne = 1
RxDne  input  1  one-cycle strobe: new message on MIDI_data
RegData  output  16  {1'b0, note[6:0], 1'b0, vel[6:0]} for the enabled register
RegEn  output  VOICES  one-hot load strobe, 1 cycle
RegClr  output  VOICES  clear strobe, 1 cycle; one-hot or all-ones
Active  output  VOICES  voice occupancy, bit v = 1 means voice v holds a note
Overrun  output  1  1-cycle pulse when RxDne arrives while busy

Behaviour:
- One clock, Clk. Reset is synchronous and active-high on Rst_p.
- While Rst_p = 1: RegData = 0, RegEn = 0, RegClr = 0, Active = 0, Overrun = 0. Note table cleared, StealPtr = 0, FSM = IDLE.
- Reset asserted mid-operation aborts the message; no strobe is issued afterwards.
- FSM: IDLE -> DECODE -> SEARCH -> ISSUE -> IDLE. Each state lasts one cycle.
- IDLE + RxDne: latch MIDI_data, go to DECODE. Otherwise stay in IDLE.
- RxDne in any state other than IDLE: message dropped, Overrun pulses the next cycle, FSM unaffected.
- Latency: RxDne at cycle N gives RegEn/RegClr at cycle N+3. Minimum message spacing is 4 cycles.
- DECODE: cmd = status[7:4], chan = status[3:0]. Classify the message as:
  - Ignore if CHAN_MASK[chan] = 0, or data1[7] = 1, or data2[7] = 1.
  - NoteOn: cmd = 9 and vel != 0.
  - NoteOff: cmd = 8, or cmd = 9 with vel = 0.
  - AllOff: cmd = B and data1 is 120 or 123.
  - Any other message: Ignore.
- Note table: per voice, a valid bit plus note[6:0]. Channel is not stored, so equal pitches on different channels share a voice.
- SEARCH, match: lowest-index valid voice whose note equals the incoming note.
- SEARCH, free: lowest-index invalid voice.
- ISSUE, NoteOn:
  - Match exists: retrigger that voice. RegEn[match] = 1, velocity updated.
  - Else a free voice exists: RegEn[free] = 1, table entry set valid.
  - Else steal: RegEn[StealPtr] = 1, table entry overwritten, StealPtr = (StealPtr + 1) mod VOICES.
  - StealPtr advances only on a steal.
  - RegData = {0, note, 0, vel}.
- ISSUE, NoteOff with a match: RegClr[match] = 1, entry invalidated, RegData = 0. With no match: no strobe, no state change.
- ISSUE, AllOff: RegClr = all ones, table cleared, StealPtr = 0, RegData = 0.
- ISSUE, Ignore: no strobe.
- RegEn and RegClr are never both nonzero in the same cycle.
- RegData changes only in ISSUE cycles that issue a strobe, and holds its value otherwise.
- Active mirrors the table valid bits and updates in the same edge as the strobe.

Test Plan:
- Reset, then 0x903C64 -> at N+3 RegEn = 8'h01, RegData = 16'h3C64. Active = 8'h01 from N+3.
- Fill all 8 voices with notes 0x30..0x37, then send 0x923864 -> RegEn = 8'h01 (steal voice 0), StealPtr = 1. A further 0x903964 -> RegEn = 8'h02.
- With voice 3 holding note 0x33: send 0x803300 -> RegClr = 8'h08, Active[3] = 0. Then send 0x903300 (vel 0) -> no strobe.
- Send 0x903C40 twice -> the second goes to the same voice, RegEn = 8'h01, RegData = 16'h3C40, Active stays 8'h01.
- CHAN_MASK = 16'h0001: 0x913C64 -> no strobe. Then 0xB07B00 -> RegClr = 8'hFF, Active = 0.
- RxDne at N and N+2 -> Overrun pulses at N+3, only the first message is issued. Asserting Rst_p at N+2 -> no strobe, all outputs 0.
